conv_window_mac: RTL and testbench

//  Convolution compute stage directly downstream of the line-buffer shift-register block.

---
 rtl/conv_window_mac.sv | 182 ++++++++++++++++++
 tb/tb_conv_window_mac.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_mac.sv
// conv_window_mac: KxK signed window MAC stage fed by the line-buffer block.
// Per-tap multipliers (S1) -> full-precision sum (S2) -> round/shift/saturate (S3).
// Row/column tracking drops windows that wrap a row or are not yet fully formed.
// Optional build macro: CONV_RELU_EN fuses a ReLU clamp into S3 (negative -> 0).

// One tap lane: registered signed product, loaded only for accepted windows.
module conv_tap_mul #(
  parameter int DATA_WIDTH = 8,
  parameter int COEF_WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  en,
  input  logic signed [DATA_WIDTH-1:0]          tap,
  input  logic signed [COEF_WIDTH-1:0]          coef,
  output logic signed [DATA_WIDTH+COEF_WIDTH-1:0] prod
);
  localparam int PW = DATA_WIDTH + COEF_WIDTH;

  // S1 product register; holds between accepted windows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    prod <= '0;
    else if (en) prod <= PW'(tap) * PW'(coef);
  end
endmodule

module conv_window_mac #(
  parameter int DATA_WIDTH  = 8,
  parameter int COEF_WIDTH  = 8,
  parameter int ROW_LENGTH  = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int OUT_WIDTH   = 8,
  parameter int SHIFT       = 0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   frame_start,
  input  logic                                   win_valid,
  input  logic signed [DATA_WIDTH-1:0]           win [0:KERNEL_SIZE*KERNEL_SIZE-1],
  input  logic                                   coef_we,
  input  logic [$clog2(KERNEL_SIZE*KERNEL_SIZE)-1:0] coef_addr,
  input  logic signed [COEF_WIDTH-1:0]           coef_data,
  output logic                                   pix_valid,
  output logic signed [OUT_WIDTH-1:0]            pix_out,
  output logic [$clog2(ROW_LENGTH)-1:0]          pix_col
);
  localparam int NTAPS     = KERNEL_SIZE * KERNEL_SIZE;
  localparam int AW        = $clog2(NTAPS);
  localparam int CW        = $clog2(ROW_LENGTH);
  localparam int RW        = (KERNEL_SIZE > 2) ? $clog2(KERNEL_SIZE) : 1;
  localparam int PW        = DATA_WIDTH + COEF_WIDTH;
  localparam int ACC_WIDTH = DATA_WIDTH + COEF_WIDTH + $clog2(NTAPS);
  localparam int STAGES    = 3;

  // Rounding constant is half an LSB of the shifted result; zero when no shift.
  localparam int RND = (SHIFT > 0) ? (1 << ((SHIFT > 0) ? SHIFT - 1 : 0)) : 0;
  localparam logic signed [ACC_WIDTH:0] SAT_HI = (ACC_WIDTH+1)'((1 << (OUT_WIDTH-1)) - 1);
`ifdef CONV_RELU_EN
  localparam logic signed [ACC_WIDTH:0] SAT_LO = '0;
`else
  localparam logic signed [ACC_WIDTH:0] SAT_LO = (ACC_WIDTH+1)'(-(1 << (OUT_WIDTH-1)));
`endif

  // position tracking
  logic [CW-1:0] col, col_eff, col_nxt;
  logic [RW-1:0] row, row_eff, row_nxt;
  logic          accept;

  // coefficient bank
  logic signed [COEF_WIDTH-1:0] coef [NTAPS];

  // pipeline
  logic [STAGES:1]                vld_pipe;
  logic [NTAPS-1:0][PW-1:0]       prod;
  logic signed [ACC_WIDTH-1:0]    sum_c, sum_s2;
  logic [CW-1:0]                  col_s1, col_s2;
  logic signed [ACC_WIDTH:0]      rnd_sum, shifted, sat;

  // frame_start clears the position first, so the same-cycle pixel is (row 0, col 0).
  always_comb begin
    col_eff = frame_start ? '0 : col;
    row_eff = frame_start ? '0 : row;
    accept  = win_valid && (col_eff >= CW'(KERNEL_SIZE-1)) && (row_eff >= RW'(KERNEL_SIZE-1));
    col_nxt = col_eff;
    row_nxt = row_eff;
    if (win_valid) begin
      if (col_eff == CW'(ROW_LENGTH-1)) begin
        col_nxt = '0;
        // row only needs to reach KERNEL_SIZE-1: after that every row is full height
        if (row_eff != RW'(KERNEL_SIZE-1)) row_nxt = row_eff + RW'(1);
      end else begin
        col_nxt = col_eff + CW'(1);
      end
    end
  end

  // Position counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else begin
      col <= col_nxt;
      row <= row_nxt;
    end
  end

  // Coefficient writes land on the edge, so a same-cycle window still sees old values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NTAPS; i++) coef[i] <= '0;
    end else if (coef_we && ({1'b0, coef_addr} < (AW+1)'(NTAPS))) begin
      coef[coef_addr] <= coef_data;
    end
  end

  // S1: one multiplier lane per tap.
  for (genvar i = 0; i < NTAPS; i++) begin : g_tap
    conv_tap_mul #(
      .DATA_WIDTH (DATA_WIDTH),
      .COEF_WIDTH (COEF_WIDTH)
    ) u_mul (
      .clk  (clk),
      .rst  (rst),
      .en   (accept),
      .tap  (win[i]),
      .coef (coef[i]),
      .prod (prod[i])
    );
  end

  // Adder tree over the registered products; ACC_WIDTH cannot overflow.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < NTAPS; i++) sum_c = sum_c + ACC_WIDTH'($signed(prod[i]));
  end

  // Valid shift register; no backpressure, so it always advances.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_pipe <= '0;
    else      vld_pipe <= {vld_pipe[STAGES-1:1], accept};
  end

  // S1 column capture and S2 sum/column registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_s1 <= '0;
      col_s2 <= '0;
      sum_s2 <= '0;
    end else begin
      if (accept)      col_s1 <= col_eff;
      if (vld_pipe[1]) begin
        sum_s2 <= sum_c;
        col_s2 <= col_s1;
      end
    end
  end

  // Round half up, arithmetic shift, then clamp to the output range (one extra bit
  // of headroom keeps the rounding add from wrapping).
  always_comb begin
    rnd_sum = (ACC_WIDTH+1)'(sum_s2) + (ACC_WIDTH+1)'(RND);
    shifted = rnd_sum >>> SHIFT;
    sat     = shifted;
    if (shifted > SAT_HI) sat = SAT_HI;
    if (shifted < SAT_LO) sat = SAT_LO;
  end

  // S3 output registers; pix_out/pix_col hold between valid pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_out <= '0;
      pix_col <= '0;
    end else if (vld_pipe[2]) begin
      pix_out <= OUT_WIDTH'(sat);
      pix_col <= col_s2;
    end
  end

  assign pix_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_conv_window_mac.sv
// Bench for conv_window_mac: two instances (SHIFT=0 and SHIFT=4) share stimulus.
// A spec-level model predicts each output (value, column, due cycle); a compare
// process checks every cycle. Directed phases pin literal values.
module tb_conv_window_mac;
  logic clk = 1'b0;
  logic rst, frame_start, win_valid, coef_we;
  logic signed [7:0] win [0:8];
  logic [3:0] coef_addr;
  logic signed [7:0] coef_data;
  logic pv0, pv4;
  logic signed [7:0] po0, po4;
  logic [4:0] pc0, pc4;

  always #5 clk = ~clk;

  conv_window_mac #(.SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .win_valid(win_valid), .win(win),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .pix_valid(pv0), .pix_out(po0), .pix_col(pc0));

  conv_window_mac #(.SHIFT(4)) dut4 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .win_valid(win_valid), .win(win),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .pix_valid(pv4), .pix_out(po4), .pix_col(pc4));

`ifdef CONV_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  typedef struct { int due; int v0; int v4; int col; } exp_t;
  exp_t q[$];
  exp_t ce;

  int cyc = 0;
  int n_cmp = 0, n_bad = 0;
  int last0 = 0, last4 = 0, got_prev = 0, got_last = 0, n_valid = 0;
  int mcoef [9];
  int mcol = 0, mrow = 0;
  int t_taps [9];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  function automatic int s8(int x);
    logic [7:0] b;
    b = 8'(x);
    return int'($signed(b));
  endfunction

  // spec arithmetic: round half up, arithmetic shift, saturate, optional ReLU
  function automatic int model_px(int sum, int sh);
    int v;
    v = sum;
    if (sh > 0) v = (v + (1 << (sh - 1))) >>> sh;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    if (RELU && v < 0) v = 0;
    return v;
  endfunction

  // per-cycle output check against the scoreboard
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due == cyc) begin
      ce = q.pop_front();
      chk("pix_valid0", int'(pv0), 1);
      chk("pix_valid4", int'(pv4), 1);
      chk("pix_out0", int'(po0), ce.v0);
      chk("pix_out4", int'(po4), ce.v4);
      chk("pix_col0", int'(pc0), ce.col);
      chk("pix_col4", int'(pc4), ce.col);
      last0 = ce.v0;
      last4 = ce.v4;
    end else begin
      chk("idle_valid0", int'(pv0), 0);
      chk("idle_valid4", int'(pv4), 0);
      chk("hold_out0", int'(po0), last0);
      chk("hold_out4", int'(po4), last4);
    end
    if (pv0) begin
      n_valid++;
      got_prev = got_last;
      got_last = int'(po0);
    end
  end

  // drive one cycle of inputs and advance the model
  task automatic step(bit fs, bit wv, bit we, int addr, int data);
    int sum;
    @(negedge clk); #1;
    frame_start = fs;
    win_valid   = wv;
    for (int i = 0; i < 9; i++) win[i] = 8'(t_taps[i]);
    coef_we   = we;
    coef_addr = 4'(addr);
    coef_data = 8'(data);
    if (fs) begin mcol = 0; mrow = 0; end
    if (wv) begin
      if (mcol >= 2 && mrow >= 2) begin
        sum = 0;
        for (int i = 0; i < 9; i++) sum += t_taps[i] * mcoef[i];
        q.push_back('{cyc + 3, model_px(sum, 0), model_px(sum, 4), mcol});
      end
      if (mcol == 31) begin
        mcol = 0;
        if (mrow < 2) mrow++;
      end else mcol++;
    end
    if (we && addr < 9) mcoef[addr] = data;
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 0, 0, 0, 0);
  endtask

  task automatic taps_const(int v);
    for (int i = 0; i < 9; i++) t_taps[i] = v;
  endtask

  task automatic taps_rand();
    for (int i = 0; i < 9; i++) t_taps[i] = s8(int'($urandom));
  endtask

  task automatic load_coefs(int v, int centre);
    for (int i = 0; i < 9; i++) step(0, 0, 1, i, (i == 4) ? centre : v);
  endtask

  task automatic do_reset(int n);
    @(negedge clk); #1;
    rst = 1'b0;
    frame_start = 1'b0; win_valid = 1'b0; coef_we = 1'b0;
    q.delete();
    last0 = 0; last4 = 0;
    mcol = 0; mrow = 0;
    for (int i = 0; i < 9; i++) mcoef[i] = 0;
    repeat (n) @(negedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; frame_start = 1'b0; win_valid = 1'b0; coef_we = 1'b0;
    coef_addr = '0; coef_data = '0;
    for (int i = 0; i < 9; i++) begin win[i] = '0; mcoef[i] = 0; t_taps[i] = 0; end
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;

    // model pins from hand-worked values
    chk("pin_sat_pos", model_px(900, 0), 127);
    chk("pin_shift4", model_px(900, 4), 56);
    chk("pin_sat_neg", model_px(-147456, 0), RELU ? 0 : -128);
    chk("pin_neg_round", model_px(-24, 4), RELU ? 0 : -1);

    // identity kernel over a 32x32 ramp frame
    load_coefs(0, 1);
    idle(5);
    n_valid = 0;
    for (int p = 0; p < 1024; p++) begin
      for (int i = 0; i < 9; i++) t_taps[i] = s8(p + i - 4);
      step(p == 0, 1, 0, 0, 0);
    end
    idle(5);
    chk("frame_pulses", n_valid, 900);
    chk("ramp_last", got_last, RELU ? 0 : -1);

    // randomized traffic: sparse valid, coef writes (some out of range), rare frame_start
    for (int k = 0; k < 3000; k++) begin
      taps_rand();
      step(($urandom_range(299) == 0), ($urandom_range(3) != 0), ($urandom_range(7) == 0),
           int'($urandom_range(15)), s8(int'($urandom)));
    end
    idle(5);

    // positive saturation and shift/round
    load_coefs(1, 1);
    taps_const(100);
    for (int n = 0; n < 70; n++) step(n == 0, 1, 0, 0, 0);
    idle(5);
    chk("sat_pos_out0", int'(po0), 127);
    chk("shift4_out4", int'(po4), 56);

    // negative saturation
    load_coefs(127, 127);
    taps_const(-128);
    for (int n = 0; n < 70; n++) step(n == 0, 1, 0, 0, 0);
    idle(5);
    chk("sat_neg_out0", int'(po0), RELU ? 0 : -128);
    chk("sat_neg_out4", int'(po4), RELU ? 0 : -128);

    // coef write on the same cycle as an accepted window
    load_coefs(0, 1);
    taps_const(10);
    for (int n = 0; n < 67; n++) step(n == 0, 1, 0, 0, 0);
    step(0, 1, 1, 4, 2);
    step(0, 1, 0, 0, 0);
    idle(5);
    chk("coef_old_out", got_prev, 10);
    chk("coef_new_out", got_last, 20);

    // reset with windows in flight
    for (int n = 0; n < 10; n++) step(0, 1, 0, 0, 0);
    do_reset(3);
    idle(4);
    n_valid = 0;
    for (int n = 0; n < 70; n++) begin
      taps_rand();
      step(0, 1, 0, 0, 0);
    end
    idle(5);
    chk("post_reset_pulses", n_valid, 4);
    chk("post_reset_zero", got_last, 0);

    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
